// File: rtl/tamagotchi_button_conditioner.sv
// Conditions six raw pushbuttons into FSM-ready commands: 2-flop sync, debounce,
// stretched press pulses on action buttons and long-press pulses on reset/test.
module tamagotchi_button_conditioner #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4000000,
  parameter int LONG_CYCLES     = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_salud,
  input  logic       raw_energia,
  input  logic       raw_hambre,
  input  logic       raw_diversion,
  input  logic       raw_reset,
  input  logic       raw_test,
  output logic       btn_salud,
  output logic       btn_energia,
  output logic       btn_hambre,
  output logic       btn_diversion,
  output logic       btn_reset,
  output logic       btn_test,
  output logic [5:0] pressed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LD  = PW'(PULSE_CYCLES);
  localparam logic [LW:0]   HOLD_LAST = (LW + 1)'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, FIRE, WAIT_REL} lp_state_t;

  logic [5:0] raw_vec;
  logic [5:0] lvl;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [5:0] db_level;
  logic [5:0] db_prev;
  logic [3:0] act_out;
  logic [1:0] long_out;

  // Channel order matches the pressed bus: {test,reset,diversion,hambre,energia,salud}
  assign raw_vec = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};
  assign lvl     = raw_vec ^ {6{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db_prev <= '0;
    end else begin
      sync1   <= lvl;
      sync2   <= sync1;
      db_prev <= db_level;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_db
    logic [DW-1:0] db_cnt;
    logic          level_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync2[g] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= ~level_q;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign db_level[g] = level_q;
  end

  // A rise while still stretching reloads the counter, so the pulse always ends
  // PULSE_CYCLES after the most recent press.
  for (genvar g = 0; g < 4; g++) begin : g_act
    logic [PW-1:0] pulse_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        pulse_cnt <= '0;
      end else if (db_level[g] && !db_prev[g]) begin
        pulse_cnt <= PULSE_LD;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end

    assign act_out[g] = (pulse_cnt != '0);
  end

  for (genvar g = 0; g < 2; g++) begin : g_long
    lp_state_t     state, state_n;
    logic [LW-1:0] hold_cnt, hold_n;
    logic [PW-1:0] pulse_cnt, pulse_n;
    logic          held;

    assign held = db_level[4 + g];

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        pulse_cnt <= '0;
      end else begin
        state     <= state_n;
        hold_cnt  <= hold_n;
        pulse_cnt <= pulse_n;
      end
    end

    always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      pulse_n = pulse_cnt;
      case (state)
        IDLE: begin
          if (held) begin
            state_n = HOLD;
            hold_n  = '0;
          end
        end
        HOLD: begin
          if (!held) begin
            state_n = IDLE;
          end else if (({1'b0, hold_cnt} + 1'b1) >= HOLD_LAST) begin
            // Firing on the cycle the count would reach LONG_CYCLES-1
            state_n = FIRE;
            pulse_n = PULSE_LD;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        FIRE: begin
          pulse_n = pulse_cnt - 1'b1;
          if (pulse_cnt == PW'(1)) state_n = WAIT_REL;
        end
        WAIT_REL: begin
          if (!held) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    assign long_out[g] = (state == FIRE);
  end

  assign btn_salud     = act_out[0];
  assign btn_energia   = act_out[1];
  assign btn_hambre    = act_out[2];
  assign btn_diversion = act_out[3];
  assign btn_reset     = long_out[0];
  assign btn_test      = long_out[1];
  assign pressed       = db_level;

endmodule
